// File: rtl/imem_loader.sv
// Boot loader: receives a length-prefixed, checksummed byte stream and writes
// little-endian 32-bit words into instruction memory, holding the CPU in reset until verified.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_reset,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t      state, state_next;
  logic [1:0]  byte_cnt;
  logic [31:0] word_idx;
  logic [31:0] word_count;
  logic [23:0] shift_reg;
  logic [7:0]  sum;

  logic        accept;
  logic        start_ok;
  logic [31:0] assembled;
  logic [7:0]  sum_next;

  // Incoming byte lands on top, so after four bytes byte 0 sits in [7:0].
  assign accept    = in_valid && in_ready;
  assign start_ok  = start && (state == S_IDLE || state == S_DONE || state == S_ERROR);
  assign assembled = {in_data, shift_reg};
  assign sum_next  = sum + in_data;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: if (start) state_next = S_LEN;
      S_LEN: begin
        if (accept && byte_cnt == 2'd3) begin
          if (assembled > DEPTH)       state_next = S_ERROR;
          else if (assembled == 32'd0) state_next = S_CSUM;
          else                         state_next = S_DATA;
        end
      end
      S_DATA: begin
        if (accept && byte_cnt == 2'd3 && word_idx == word_count - 32'd1)
          state_next = S_CSUM;
      end
      S_CSUM: begin
        if (accept) state_next = (sum_next == 8'd0) ? S_DONE : S_ERROR;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Byte/word bookkeeping and the registered memory write port.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt   <= 2'd0;
      word_idx   <= 32'd0;
      word_count <= 32'd0;
      shift_reg  <= 24'd0;
      sum        <= 8'd0;
      mem_we     <= 1'b0;
      mem_addr   <= 32'd0;
      mem_wdata  <= 32'd0;
    end else begin
      mem_we <= 1'b0;
      if (start_ok) begin
        byte_cnt  <= 2'd0;
        word_idx  <= 32'd0;
        shift_reg <= 24'd0;
        sum       <= 8'd0;
      end else if (accept) begin
        sum       <= sum_next;
        byte_cnt  <= byte_cnt + 2'd1;
        shift_reg <= assembled[31:8];
        if (state == S_LEN && byte_cnt == 2'd3)
          word_count <= assembled;
        if (state == S_DATA && byte_cnt == 2'd3) begin
          mem_we    <= 1'b1;
          mem_addr  <= BASE_ADDR + {word_idx[29:0], 2'b00};
          mem_wdata <= assembled;
          word_idx  <= word_idx + 32'd1;
        end
      end
    end
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      cpu_reset <= 1'b1;
    end else begin
      in_ready  <= (state_next == S_LEN || state_next == S_DATA || state_next == S_CSUM);
      busy      <= (state_next == S_LEN || state_next == S_DATA || state_next == S_CSUM);
      done      <= (state_next == S_DONE);
      error     <= (state_next == S_ERROR);
      cpu_reset <= (state_next != S_DONE);
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a byte-history reference model checked every cycle,
// plus directed loads with literal expectations and randomized loads.
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          DEPTH = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, mem_we, cpu_reset, busy, done, error;
  logic [31:0] mem_addr, mem_wdata;

  imem_loader #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  // Model: 0 idle, 1 loading, 2 done, 3 error; outputs derived from accepted-byte history.
  int          mode = 0;
  logic [7:0]  hist[$];
  logic        we_m = 1'b0;
  logic [31:0] addr_m = 32'd0;
  logic [31:0] data_m = 32'd0;

  typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
  wr_t wlog[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic modelAccept(input logic [7:0] b);
    int          k;
    logic [31:0] nword;
    longint      n;
    logic [7:0]  s;
    hist.push_back(b);
    k = hist.size();
    n = 0;
    if (k >= 4) begin
      nword = {hist[3], hist[2], hist[1], hist[0]};
      n = longint'(nword);
    end
    if (k == 4 && n > DEPTH) begin
      mode = 3;
    end else if (k > 4 && k <= 4 + 4 * n && (k % 4) == 0) begin
      we_m   = 1'b1;
      addr_m = BASE + 32'(k - 8);
      data_m = {hist[k-1], hist[k-2], hist[k-3], hist[k-4]};
    end else if (k >= 5 && k == 4 * n + 5) begin
      s = 8'd0;
      foreach (hist[i]) s = s + hist[i];
      mode = (s == 8'd0) ? 2 : 3;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode = 0;
      hist.delete();
      we_m = 1'b0;
      addr_m = 32'd0;
      data_m = 32'd0;
    end else begin
      we_m = 1'b0;
      if (mode != 1 && start) begin
        mode = 1;
        hist.delete();
      end else if (mode == 1 && in_valid) begin
        modelAccept(in_data);
      end
    end
  end

  always @(negedge clk) begin
    checkOutput("in_ready",  32'(in_ready),  32'(mode == 1));
    checkOutput("busy",      32'(busy),      32'(mode == 1));
    checkOutput("done",      32'(done),      32'(mode == 2));
    checkOutput("error",     32'(error),     32'(mode == 3));
    checkOutput("cpu_reset", 32'(cpu_reset), 32'(mode != 2));
    checkOutput("mem_we",    32'(mem_we),    32'(we_m));
    checkOutput("mem_addr",  mem_addr,       addr_m);
    checkOutput("mem_wdata", mem_wdata,      data_m);
    if (mem_we) wlog.push_back('{addr: mem_addr, data: mem_wdata});
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int gap, input logic st);
    in_valid = 1'b1;
    in_data  = b;
    start    = st;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    start    = 1'b0;
    idle(gap);
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic sendLoad(input logic [7:0] bytes[$], input int gap);
    foreach (bytes[i]) applyStimulus(bytes[i], gap, 1'b0);
  endtask

  task automatic checkWrites(input string name, input int n,
                             input logic [31:0] a0, input logic [31:0] d0,
                             input logic [31:0] a1, input logic [31:0] d1);
    checkOutput({name, "_count"}, 32'(wlog.size()), 32'(n));
    if (n >= 1 && wlog.size() >= 1) begin
      checkOutput({name, "_addr0"}, wlog[0].addr, a0);
      checkOutput({name, "_data0"}, wlog[0].data, d0);
    end
    if (n >= 2 && wlog.size() >= 2) begin
      checkOutput({name, "_addr1"}, wlog[1].addr, a1);
      checkOutput({name, "_data1"}, wlog[1].data, d1);
    end
  endtask

  task automatic checkStatus(input string name, input logic r, input logic b,
                             input logic d, input logic e, input logic c);
    checkOutput({name, "_in_ready"},  32'(in_ready),  32'(r));
    checkOutput({name, "_busy"},      32'(busy),      32'(b));
    checkOutput({name, "_done"},      32'(done),      32'(d));
    checkOutput({name, "_error"},     32'(error),     32'(e));
    checkOutput({name, "_cpu_reset"}, 32'(cpu_reset), 32'(c));
  endtask

  logic [7:0] two_word[$] = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00,
                              8'h13, 8'h01, 8'h10, 8'h00, 8'hF7};

  initial begin
    logic [7:0] q[$];
    logic [7:0] s;
    int         n;
    int         abort_at;

    #2 reset = 1'b0;
    idle(2);
    checkStatus("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    reset = 1'b1;
    idle(1);

    // Two-word load
    wlog.delete();
    pulseStart();
    sendLoad(two_word, 0);
    checkWrites("two_word", 2, 32'h0, 32'h0050_0093, 32'h4, 32'h0010_0113);
    checkStatus("two_word", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Bad checksum
    wlog.delete();
    q = two_word;
    q[12] = 8'hF6;
    pulseStart();
    sendLoad(q, 0);
    checkWrites("bad_csum", 2, 32'h0, 32'h0050_0093, 32'h4, 32'h0010_0113);
    checkStatus("bad_csum", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(2);

    // Zero length
    wlog.delete();
    pulseStart();
    q = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    sendLoad(q, 0);
    checkWrites("zero_len", 0, 32'h0, 32'h0, 32'h0, 32'h0);
    checkStatus("zero_len", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Oversize length (1025 words)
    wlog.delete();
    pulseStart();
    q = '{8'h01, 8'h04, 8'h00, 8'h00};
    sendLoad(q, 0);
    checkStatus("oversize", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    q = '{8'h11, 8'h22, 8'h33};
    sendLoad(q, 0);
    checkWrites("oversize", 0, 32'h0, 32'h0, 32'h0, 32'h0);
    checkStatus("oversize_late", 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Gapped stream, then reload start from DONE
    wlog.delete();
    pulseStart();
    sendLoad(two_word, 3);
    checkWrites("gapped", 2, 32'h0, 32'h0050_0093, 32'h4, 32'h0010_0113);
    checkStatus("gapped", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    pulseStart();
    checkStatus("reload", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Reset mid-load after 6 data bytes
    wlog.delete();
    for (int i = 0; i < 10; i++) applyStimulus(two_word[i], 0, 1'b0);
    #2 reset = 1'b0;
    #1;
    checkStatus("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    checkOutput("mid_reset_mem_we", 32'(mem_we), 32'h0);
    checkOutput("mid_reset_mem_addr", mem_addr, 32'h0);
    checkOutput("mid_reset_mem_wdata", mem_wdata, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    checkWrites("aborted", 1, 32'h0, 32'h0050_0093, 32'h0, 32'h0);
    wlog.delete();
    pulseStart();
    sendLoad(two_word, 0);
    checkWrites("after_reset", 2, 32'h0, 32'h0050_0093, 32'h4, 32'h0010_0113);
    checkStatus("after_reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Exactly DEPTH words is accepted
    wlog.delete();
    q = '{8'h00, 8'h04, 8'h00, 8'h00};
    s = 8'h04;
    for (int i = 0; i < 4 * DEPTH; i++) begin
      q.push_back(8'($urandom));
      s = s + q[q.size() - 1];
    end
    q.push_back(8'h00 - s);
    pulseStart();
    sendLoad(q, 0);
    checkOutput("full_depth_count", 32'(wlog.size()), 32'(DEPTH));
    checkStatus("full_depth", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(2);

    // Randomized loads, the model checks every cycle
    for (int it = 0; it < 40; it++) begin
      n = ($urandom_range(0, 9) == 0) ? 1025 + $urandom_range(0, 3000) : $urandom_range(0, 6);
      q = '{8'(n), 8'(n >> 8), 8'(n >> 16), 8'(n >> 24)};
      if (n > DEPTH) begin
        for (int i = 0; i < 3; i++) q.push_back(8'($urandom));
      end else begin
        s = q[0] + q[1] + q[2] + q[3];
        for (int i = 0; i < 4 * n; i++) begin
          q.push_back(8'($urandom));
          s = s + q[q.size() - 1];
        end
        if ($urandom_range(0, 3) == 0) q.push_back(8'h00 - s + 8'($urandom_range(1, 255)));
        else                           q.push_back(8'h00 - s);
      end
      abort_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, q.size() - 1) : -1;
      pulseStart();
      foreach (q[i]) begin
        if (i == abort_at) begin
          #2 reset = 1'b0;
          @(posedge clk);
          @(posedge clk);
          #1 reset = 1'b1;
          break;
        end
        applyStimulus(q[i], $urandom_range(0, 2), ($urandom_range(0, 15) == 0));
      end
      idle(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that is the writing side of the instruction memory the CPU fetches from. It accepts a byte stream over a valid/ready handshake, checks its length and checksum, assembles little-endian 32-bit words and writes them into instruction memory. It holds the CPU in reset for the whole load and releases it only after a verified load.

## Interface
Parameters:
- BASE_ADDR, 32'h0000_0000, byte address of the first instruction word written.
- DEPTH_WORDS, 1024, instruction-memory capacity in 32-bit words; longer loads are rejected.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  single-cycle pulse that begins a load; honoured only in IDLE, DONE or ERROR
- in_valid  in  1  stream byte present
- in_data  in  8  stream byte
- in_ready  out  1  loader accepts a byte; transfer occurs when in_valid && in_ready
- mem_we  out  1  one-cycle instruction-memory write strobe
- mem_addr  out  32  byte address of the write, word aligned
- mem_wdata  out  32  write data
- cpu_reset  out  1  active-high reset to the CPU
- busy  out  1  high in LEN, DATA and CSUM
- done  out  1  high in DONE
- error  out  1  high in ERROR

## Operation
- Stream format:
  - 4 length bytes, little-endian word count N.
  - 4*N data bytes; each word is sent little-endian.
  - 1 checksum byte. The 8-bit sum of all length bytes, all data bytes and the checksum must be 0 mod 256.
- FSM states: IDLE, LEN, DATA, CSUM, DONE, ERROR.
  - IDLE/DONE/ERROR + start -> LEN. Clears the byte counter, word index, sum and the done/error flags.
  - LEN: accepts 4 bytes. After the 4th byte:
    - N > DEPTH_WORDS -> ERROR.
    - N == 0 -> CSUM.
    - otherwise -> DATA.
  - DATA: accepts bytes into a shift register, byte 0 in bits [7:0]. On the 4th byte of a word, register the write.
    - After word N-1 -> CSUM.
  - CSUM: accepts 1 byte.
    - (sum + byte) mod 256 == 0 -> DONE.
    - otherwise -> ERROR.
  - DONE and ERROR are terminal until start or reset.
- Checksum accumulator is 8 bits, wraps mod 256, and is updated on every accepted byte.
- Word index is 32 bits. Write address = BASE_ADDR + 4*index, modulo 2^32.
- cpu_reset:
  - 1 in every state except DONE.
  - A start pulse in DONE reasserts it on the next cycle.
- start while busy is ignored.
- in_valid outside LEN/DATA/CSUM is ignored; no byte is consumed.

## Timing
- Reset values:
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_reset=1, busy=0, done=0, error=0.
  - State IDLE.
- Reset is asynchronous and may occur mid-load. It aborts the load immediately with all outputs at reset values. Any partially assembled word is never written.
- in_ready is a registered output. It is 1 exactly while in LEN, DATA or CSUM, starting the cycle after start is sampled.
- Write latency:
  - The cycle after the 4th byte of a word is accepted, mem_we=1 for exactly one cycle with mem_addr and mem_wdata valid.
  - mem_addr and mem_wdata hold their last values afterwards.
- No backpressure stalls. The loader sustains 1 byte per cycle, so back-to-back words give a mem_we pulse every 4 cycles.
- Terminal transitions:
  - State moves to DONE or ERROR the cycle after the checksum byte is accepted.
  - In DONE, cpu_reset=0 on that same cycle.
  - The last data write always precedes that cycle.
- Oversize length: ERROR the cycle after the 4th length byte. in_ready=0 from then on, and no write ever occurs.
- A gap in in_valid, held low for any number of cycles, changes nothing except delaying the stream.

## Test plan
- Two-word load, BASE_ADDR=0:
  - Stimulus: start, then bytes 02 00 00 00 93 00 50 00 13 01 10 00 F7.
  - Required: mem_we at addr 0 with 32'h00500093, then at addr 4 with 32'h00100113. Then done=1, cpu_reset=0, busy=0.
- Bad checksum:
  - Stimulus: same stream with last byte F6.
  - Required: both writes still occur, then error=1, cpu_reset=1, done=0.
- Zero length:
  - Stimulus: bytes 00 00 00 00 00.
  - Required: no mem_we pulse, done=1, cpu_reset=0.
- Oversize, DEPTH_WORDS=1024:
  - Stimulus: length bytes 01 04 00 00 (N=1025).
  - Required: error=1 the next cycle, in_ready=0, no mem_we, later bytes ignored.
- Gapped stream and reload:
  - Stimulus: the two-word load with in_valid low for 3 cycles between every byte, then a start pulse in DONE.
  - Required: identical writes and DONE. After the start pulse, cpu_reset=1 and busy=1 the next cycle.
- Reset mid-load:
  - Stimulus: drop reset after 6 data bytes, release it, then repeat the full two-word load.
  - Required: all outputs at reset values while reset is low, no write from the aborted word, and the second load completes exactly as in the two-word load scenario.
